// File: rtl/count_checker.sv
// Receive-side monitor for an enable-gated binary counter: predicts each count, locks after
// LOCK_COUNT good increments, then flags deviations and wrap-around. Option: COUNT_CHECKER_STICKY_EN.
module count_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             count_clr,
`ifdef COUNT_CHECKER_STICKY_EN
    input  logic             sticky_clr,
`endif
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_pulse
`ifdef COUNT_CHECKER_STICKY_EN
    ,
    output logic             fault_sticky
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic             prev_clr;
    logic [3:0]       run;

    logic [WIDTH-1:0] expected;
    logic             match;
    logic             incr;
    logic [3:0]       run_inc;
    logic             err_detect;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        expected = prev_count;
        if (prev_clr)
            expected = '0;
        else if (prev_en)
            expected = prev_count + ONE;
    end

    assign match      = (count_in == expected);
    assign incr       = prev_en & ~prev_clr;
    assign run_inc    = run + 4'd1;
    assign err_detect = (state == LOCKED) && !match;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev_count <= '0;
            prev_en    <= 1'b0;
            prev_clr   <= 1'b0;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            prev_count <= count_in;
            prev_en    <= enable;
            prev_clr   <= count_clr;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;

            case (state)
                // First sample after reset has nothing to be compared against.
                IDLE: begin
                    run   <= '0;
                    state <= ACQUIRE;
                end

                // Holds and clears neither advance nor break the run of good increments.
                ACQUIRE: begin
                    if (!match) begin
                        run <= '0;
                    end else if (incr) begin
                        run <= run_inc;
                        if (run_inc == LOCK_TARGET) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end

                LOCKED: begin
                    if (!match) begin
                        err_pulse <= 1'b1;
                        if (err_count != ERR_MAX)
                            err_count <= err_count + 1'b1;
                        locked <= 1'b0;
                        run    <= '0;
                        state  <= ACQUIRE;
                    end else if (incr && (prev_count == ALL_ONES) && (count_in == '0)) begin
                        wrap_pulse <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    run    <= '0;
                end
            endcase
        end
    end

`ifdef COUNT_CHECKER_STICKY_EN
    // A fresh error outranks a clear request in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fault_sticky <= 1'b0;
        else if (err_detect)
            fault_sticky <= 1'b1;
        else if (sticky_clr)
            fault_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_count_checker.sv
// Randomized self-checking bench for count_checker against a behavioural model of the
// counter-monitoring rules, plus directed scenarios with literal expectations.
module tb_count_checker;

    localparam int LOCK = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       count_clr = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       wrap_pulse;
`ifdef COUNT_CHECKER_STICKY_EN
    logic       sticky_clr = 1'b0;
    logic       fault_sticky;
`endif

    int total = 0;
    int bad   = 0;

    count_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .ERR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .count_clr  (count_clr),
`ifdef COUNT_CHECKER_STICKY_EN
        .sticky_clr (sticky_clr),
`endif
        .count_in   (count_in),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse)
`ifdef COUNT_CHECKER_STICKY_EN
        ,
        .fault_sticky (fault_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: history of the last sample, whether the monitor trusts the
    // counter, and how many good increments it has seen in a row.
    bit         m_have   = 0;
    int         m_prev   = 0;
    bit         m_pen    = 0;
    bit         m_pclr   = 0;
    bit         m_lock   = 0;
    int         m_streak = 0;
    int         m_err    = 0;
    bit         m_errp   = 0;
    bit         m_wrap   = 0;
    bit         m_sticky = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_have = 0; m_prev = 0; m_pen = 0; m_pclr = 0; m_lock = 0;
            m_streak = 0; m_err = 0; m_errp = 0; m_wrap = 0; m_sticky = 0;
        end else begin
            int  want;
            bit  ok;
            want   = m_pclr ? 0 : (m_pen ? (m_prev + 1) % 256 : m_prev);
            ok     = (int'(count_in) == want);
            m_errp = 0;
            m_wrap = 0;
            if (m_have) begin
                if (m_lock) begin
                    if (!ok) begin
                        m_errp   = 1;
                        m_err    = (m_err < 255) ? m_err + 1 : 255;
                        m_lock   = 0;
                        m_streak = 0;
                    end else if (m_prev == 255 && m_pen && !m_pclr && count_in == 8'h00) begin
                        m_wrap = 1;
                    end
                end else if (!ok) begin
                    m_streak = 0;
                end else if (m_pen && !m_pclr) begin
                    m_streak++;
                    if (m_streak >= LOCK) m_lock = 1;
                end
            end
`ifdef COUNT_CHECKER_STICKY_EN
            if (m_errp) m_sticky = 1;
            else if (sticky_clr) m_sticky = 0;
`endif
            m_have = 1;
            m_prev = int'(count_in);
            m_pen  = enable;
            m_pclr = count_clr;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            check("locked", locked, m_lock);
            check("err_pulse", err_pulse, m_errp);
            check("err_count", err_count, m_err);
            check("wrap_pulse", wrap_pulse, m_wrap);
`ifdef COUNT_CHECKER_STICKY_EN
            check("fault_sticky", fault_sticky, m_sticky);
`endif
        end
    end

    // Behaviour of a healthy counter: count_in reflects last cycle's enable/clear.
    logic [7:0] cnt    = 8'h00;
    logic       last_e = 1'b0;
    logic       last_c = 1'b0;

    task automatic tick(input logic e, input logic c, input logic [7:0] v);
        @(negedge clk);
        enable    = e;
        count_clr = c;
        count_in  = v;
        @(posedge clk);
        #1;
        cnt    = v;
        last_e = e;
        last_c = c;
    endtask

    task automatic good(input logic e, input logic c);
        logic [7:0] v;
        v = last_c ? 8'h00 : (last_e ? cnt + 8'h01 : cnt);
        tick(e, c, v);
    endtask

    task automatic start_from_zero();
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < LOCK; i++) good(1'b1, 1'b0);
    endtask

    initial begin
        int pulses;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked", locked, 1'b0);
        check("reset_err_count", err_count, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Lock-up: sample 0 in IDLE, then 1,2,3,4.
        tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) good(1'b1, 1'b0);
        check("lock_not_at_3", locked, 1'b0);
        good(1'b1, 1'b0);
        check("lock_at_4", locked, 1'b1);
        check("lock_err_count", err_count, 8'h00);

        // Wrap-around.
        while (cnt != 8'hFD) good(1'b1, 1'b0);
        good(1'b1, 1'b0);
        check("wrap_fe", wrap_pulse, 1'b0);
        good(1'b1, 1'b0);
        check("wrap_ff", wrap_pulse, 1'b0);
        good(1'b1, 1'b0);
        check("wrap_00", wrap_pulse, 1'b1);
        check("wrap_locked", locked, 1'b1);
        good(1'b1, 1'b0);
        check("wrap_01", wrap_pulse, 1'b0);

        // Injected glitch 0x11 -> 0x13.
        while (cnt != 8'h11) good(1'b1, 1'b0);
        tick(1'b1, 1'b0, 8'h13);
        check("glitch_err_pulse", err_pulse, 1'b1);
        check("glitch_err_count", err_count, 8'h01);
        check("glitch_locked", locked, 1'b0);
        good(1'b1, 1'b0);
        check("glitch_pulse_one_cycle", err_pulse, 1'b0);
        good(1'b1, 1'b0);
        good(1'b1, 1'b0);
        check("relock_not_yet", locked, 1'b0);
        good(1'b1, 1'b0);
        check("relock_after_4", locked, 1'b1);

        // Hold for 5 cycles at 0x20, then clear together with enable.
        while (cnt != 8'h1F) good(1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            good(1'b0, 1'b0);
            pulses += int'(err_pulse) + int'(wrap_pulse);
        end
        check("hold_value", cnt, 8'h20);
        good(1'b1, 1'b1);
        pulses += int'(err_pulse) + int'(wrap_pulse);
        good(1'b1, 1'b0);
        pulses += int'(err_pulse) + int'(wrap_pulse);
        check("clear_value", cnt, 8'h00);
        check("hold_clear_pulses", pulses, 0);
        check("hold_clear_locked", locked, 1'b1);

        // Saturate the error counter: 260 locked mismatches, relocking between each.
        for (int i = 0; i < 260; i++) begin
            tick(1'b1, 1'b0, cnt + 8'h05);
            for (int j = 0; j < LOCK; j++) good(1'b1, 1'b0);
        end
        check("sat_err_count", err_count, 8'hFF);
        check("sat_locked", locked, 1'b1);

        // Asynchronous reset in the middle of a clock phase.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_err_count", err_count, 8'h00);
        check("async_locked", locked, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start_from_zero();
        check("relock_after_reset", locked, 1'b1);

`ifdef COUNT_CHECKER_STICKY_EN
        tick(1'b1, 1'b0, cnt + 8'h03);
        check("sticky_set", fault_sticky, 1'b1);
        for (int j = 0; j < LOCK; j++) good(1'b1, 1'b0);
        check("sticky_relocked", locked, 1'b1);
        check("sticky_held", fault_sticky, 1'b1);
        sticky_clr = 1'b1;
        good(1'b1, 1'b0);
        sticky_clr = 1'b0;
        check("sticky_cleared", fault_sticky, 1'b0);
`endif

        // Randomized phase: realistic counter with occasional bit-flip glitches.
        for (int i = 0; i < 3000; i++) begin
            logic       e, c;
            logic [7:0] v, mask;
            e    = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 15) == 0);
            v    = last_c ? 8'h00 : (last_e ? cnt + 8'h01 : cnt);
            mask = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 31) == 0) v = v ^ mask;
`ifdef COUNT_CHECKER_STICKY_EN
            sticky_clr = ($urandom_range(0, 7) == 0);
`endif
            tick(e, c, v);
        end
`ifdef COUNT_CHECKER_STICKY_EN
        sticky_clr = 1'b0;
`endif
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
